// File: rtl/scan_capture_if.sv
// Scan-bus bundle between a seven-segment scanner (master) and scan_capture (slave).
// The slave side carries the rebuilt digit slots and the scan health flags back.
interface scan_capture_if;
    logic [7:0]  seg_in;
    logic [4:0]  sel_in;
    logic [39:0] q;
    logic [19:0] hex;
    logic [4:0]  hv;
    logic        frame_done;
    logic        seq_err;
    logic        bad_sel;
    logic        stale;

    modport master (
        output seg_in, sel_in,
        input  q, hex, hv, frame_done, seq_err, bad_sel, stale
    );

    modport slave (
        input  seg_in, sel_in,
        output q, hex, hv, frame_done, seq_err, bad_sel, stale
    );
endinterface

// File: rtl/scan_capture.sv
// Receiver for the five-digit multiplexed seven-segment scan bus: captures each
// digit slot after a stable dwell, decodes it to BCD and flags scan-order faults.
module scan_capture #(
    parameter int unsigned STABLE_CYC = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    scan_capture_if.slave bus
);
    localparam logic [3:0]  STABLE   = 4'(STABLE_CYC);
    localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        SEL_BLANK,
        SEL_SLOT,
        SEL_BAD
    } sel_kind_e;

    // Returns {valid, digit}; dp is not part of the pattern.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = {1'b1, 4'd0};
            7'h06:   decode = {1'b1, 4'd1};
            7'h5B:   decode = {1'b1, 4'd2};
            7'h4F:   decode = {1'b1, 4'd3};
            7'h66:   decode = {1'b1, 4'd4};
            7'h6D:   decode = {1'b1, 4'd5};
            7'h7D:   decode = {1'b1, 4'd6};
            7'h07:   decode = {1'b1, 4'd7};
            7'h7F:   decode = {1'b1, 4'd8};
            7'h6F:   decode = {1'b1, 4'd9};
            default: decode = {1'b0, 4'hF};
        endcase
    endfunction

    logic [7:0]  r_seg;
    logic [4:0]  r_sel;
    logic [4:0]  p_sel;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [2:0]  exp_slot;
    logic [2:0]  exp_nxt;
    logic [4:0]  prog;
    logic [4:0]  prog_nxt;
    logic [15:0] idle;
    logic [15:0] idle_nxt;
    logic [39:0] q_r;
    logic [39:0] q_nxt;
    logic [19:0] hex_r;
    logic [19:0] hex_nxt;
    logic [4:0]  hv_r;
    logic [4:0]  hv_nxt;
    logic        done_r;
    logic        done_nxt;
    logic        err_r;
    logic        err_nxt;
    logic        bad_r;
    logic        bad_nxt;
    logic        stale_r;

    logic        changed;
    logic        qual;
    logic [4:0]  sel_low;
    logic [2:0]  slot;
    logic [4:0]  dec;
    sel_kind_e   kind;

    assign sel_low = ~r_sel;
    assign changed = (r_sel != p_sel);
    assign cnt_nxt = changed ? 4'd1 : ((cnt == 4'd15) ? cnt : cnt + 4'd1);
    // A dwell acts once: a counter parked at 15 must not re-qualify when STABLE_CYC is 15.
    assign qual    = (cnt_nxt == STABLE) && (changed || (cnt != STABLE));
    assign dec     = decode(r_seg[6:0]);

    always_comb begin
        // NOTE: every signal written here is given a default first, so no latch is inferred.
        slot = 3'd0;
        kind = SEL_BAD;
        if (sel_low == 5'd0) begin
            kind = SEL_BLANK;
        end else if ((sel_low & (sel_low - 5'd1)) == 5'd0) begin
            kind = SEL_SLOT;
        end
        for (int i = 0; i < 5; i++) begin
            if (sel_low[i]) slot = 3'(i);
        end
    end

    always_comb begin
        q_nxt    = q_r;
        hex_nxt  = hex_r;
        hv_nxt   = hv_r;
        exp_nxt  = exp_slot;
        prog_nxt = prog;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        bad_nxt  = 1'b0;
        idle_nxt = (idle == IDLE_MAX) ? idle : idle + 16'd1;

        if (qual) begin
            case (kind)
                SEL_SLOT: begin
                    q_nxt[8*slot +: 8]   = r_seg;
                    hex_nxt[4*slot +: 4] = dec[3:0];
                    hv_nxt[slot]         = dec[4];
                    if (slot != exp_slot) begin
                        err_nxt  = 1'b1;
                        prog_nxt = 5'd1 << slot;
                    end else if (slot == 3'd4 && prog[3:0] == 4'hF) begin
                        done_nxt = 1'b1;
                        prog_nxt = 5'd0;
                    end else begin
                        prog_nxt = prog | (5'd1 << slot);
                    end
                    exp_nxt  = (slot == 3'd4) ? 3'd0 : slot + 3'd1;
                    idle_nxt = 16'd0;
                end
                SEL_BAD: begin
                    bad_nxt  = 1'b1;
                    prog_nxt = 5'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_seg    <= 8'd0;
            r_sel    <= 5'b11111;
            p_sel    <= 5'b11111;
            cnt      <= 4'd0;
            exp_slot <= 3'd0;
            prog     <= 5'd0;
            idle     <= 16'd0;
            // NOTE: q is five byte registers, not a RAM, so it is reset along with the rest.
            q_r      <= 40'd0;
            hex_r    <= 20'd0;
            hv_r     <= 5'd0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            bad_r    <= 1'b0;
            stale_r  <= 1'b0;
        end else begin
            r_seg    <= bus.seg_in;
            r_sel    <= bus.sel_in;
            p_sel    <= r_sel;
            cnt      <= cnt_nxt;
            exp_slot <= exp_nxt;
            prog     <= prog_nxt;
            idle     <= idle_nxt;
            q_r      <= q_nxt;
            hex_r    <= hex_nxt;
            hv_r     <= hv_nxt;
            done_r   <= done_nxt;
            err_r    <= err_nxt;
            bad_r    <= bad_nxt;
            stale_r  <= (idle_nxt == IDLE_MAX);
        end
    end

    assign bus.q          = q_r;
    assign bus.hex        = hex_r;
    assign bus.hv         = hv_r;
    assign bus.frame_done = done_r;
    assign bus.seq_err    = err_r;
    assign bus.bad_sel    = bad_r;
    assign bus.stale      = stale_r;
endmodule

// File: tb/tb_scan_capture.sv
// Bench for scan_capture: three instances (dwell 1, dwell 3, short timeout) stepped
// together against a slot-level reference model, plus directed scenario checks.
module tb_scan_capture;
    localparam int STAB [3] = '{1, 3, 1};
    localparam int TMO  [3] = '{255, 255, 8};
    localparam logic [6:0] DIG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_capture_if bus_a ();
    scan_capture_if bus_b ();
    scan_capture_if bus_c ();

    scan_capture #(.STABLE_CYC(1), .TIMEOUT(255)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    scan_capture #(.STABLE_CYC(3), .TIMEOUT(255)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    scan_capture #(.STABLE_CYC(1), .TIMEOUT(8))   u_c (.clk(clk), .rst(rst), .bus(bus_c));

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [7:0]  in_seg [3];
    logic [4:0]  in_sel [3];

    // Reference model: slot contents, order bookkeeping and the dwell seen on the pins.
    logic [7:0]  m_q    [3][5];
    logic [3:0]  m_hex  [3][5];
    bit          m_hv   [3][5];
    bit          m_have [3][5];
    int          m_exp  [3];
    int          m_idle [3];
    bit          m_done [3];
    bit          m_err  [3];
    bit          m_bad  [3];
    logic [4:0]  m_prev [3];
    int          m_dwell[3];
    bit          p_v    [3];
    logic [7:0]  p_seg  [3];
    logic [4:0]  p_sel  [3];

    logic [39:0] o_q    [3];
    logic [19:0] o_hex  [3];
    logic [4:0]  o_hv   [3];
    logic        o_done [3];
    logic        o_err  [3];
    logic        o_bad  [3];
    logic        o_stale[3];

    function automatic logic [4:0] sel_of(input int k);
        sel_of = ~(5'b00001 << k);
    endfunction

    function automatic logic [7:0] pat_of(input int d);
        pat_of = {1'b0, DIG[d]};
    endfunction

    task automatic ref_decode(input logic [7:0] seg, output logic [3:0] h, output bit v);
        h = 4'hF;
        v = 1'b0;
        for (int d = 0; d < 10; d++) begin
            if (seg[6:0] == DIG[d]) begin
                h = 4'(d);
                v = 1'b1;
            end
        end
    endtask

    task automatic model_reset(input int i);
        for (int k = 0; k < 5; k++) begin
            m_q[i][k] = 8'd0; m_hex[i][k] = 4'd0; m_hv[i][k] = 1'b0; m_have[i][k] = 1'b0;
        end
        m_exp[i] = 0; m_idle[i] = 0;
        m_done[i] = 1'b0; m_err[i] = 1'b0; m_bad[i] = 1'b0;
        m_prev[i] = 5'h1F; m_dwell[i] = 1; p_v[i] = 1'b0;
    endtask

    task automatic model_edge(input int i);
        int z;
        int k;
        logic [3:0] h;
        bit v;
        bit cap;
        cap = 1'b0;
        m_done[i] = 1'b0; m_err[i] = 1'b0; m_bad[i] = 1'b0;
        if (rst) begin
            model_reset(i);
            return;
        end
        if (p_v[i]) begin
            z = $countones(~p_sel[i]);
            if (z == 1) begin
                k = 0;
                for (int b = 0; b < 5; b++) if (!p_sel[i][b]) k = b;
                m_q[i][k] = p_seg[i];
                ref_decode(p_seg[i], h, v);
                m_hex[i][k] = h;
                m_hv[i][k]  = v;
                if (k != m_exp[i]) begin
                    m_err[i] = 1'b1;
                    for (int b = 0; b < 5; b++) m_have[i][b] = (b == k);
                end else if (k == 4 && m_have[i][0] && m_have[i][1] && m_have[i][2] && m_have[i][3]) begin
                    m_done[i] = 1'b1;
                    for (int b = 0; b < 5; b++) m_have[i][b] = 1'b0;
                end else begin
                    m_have[i][k] = 1'b1;
                end
                m_exp[i] = (k + 1) % 5;
                cap = 1'b1;
            end else if (z > 1) begin
                m_bad[i] = 1'b1;
                for (int b = 0; b < 5; b++) m_have[i][b] = 1'b0;
            end
        end
        if (cap) m_idle[i] = 0;
        else if (m_idle[i] < TMO[i]) m_idle[i]++;
        if (in_sel[i] == m_prev[i]) begin
            if (m_dwell[i] < 1000) m_dwell[i]++;
        end else begin
            m_dwell[i] = 1;
        end
        m_prev[i] = in_sel[i];
        p_v[i]    = (m_dwell[i] == STAB[i]);
        p_sel[i]  = in_sel[i];
        p_seg[i]  = in_seg[i];
    endtask

    task automatic blank_all();
        for (int i = 0; i < 3; i++) begin
            in_sel[i] = 5'h1F;
            in_seg[i] = 8'h00;
        end
    endtask

    // One clock: drive all buses, advance the model, compare every instance against it.
    task automatic step();
        logic [39:0] eq;
        logic [19:0] eh;
        logic [4:0]  ev;
        bus_a.seg_in = in_seg[0]; bus_a.sel_in = in_sel[0];
        bus_b.seg_in = in_seg[1]; bus_b.sel_in = in_sel[1];
        bus_c.seg_in = in_seg[2]; bus_c.sel_in = in_sel[2];
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        cyc++;
        o_q[0] = bus_a.q; o_hex[0] = bus_a.hex; o_hv[0] = bus_a.hv;
        o_done[0] = bus_a.frame_done; o_err[0] = bus_a.seq_err; o_bad[0] = bus_a.bad_sel; o_stale[0] = bus_a.stale;
        o_q[1] = bus_b.q; o_hex[1] = bus_b.hex; o_hv[1] = bus_b.hv;
        o_done[1] = bus_b.frame_done; o_err[1] = bus_b.seq_err; o_bad[1] = bus_b.bad_sel; o_stale[1] = bus_b.stale;
        o_q[2] = bus_c.q; o_hex[2] = bus_c.hex; o_hv[2] = bus_c.hv;
        o_done[2] = bus_c.frame_done; o_err[2] = bus_c.seq_err; o_bad[2] = bus_c.bad_sel; o_stale[2] = bus_c.stale;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 5; k++) begin
                eq[8*k +: 8] = m_q[i][k];
                eh[4*k +: 4] = m_hex[i][k];
                ev[k]        = m_hv[i][k];
            end
            n_cmp++;
            if (o_q[i] !== eq) begin
                n_mis++; $display("FAIL q inst%0d cyc%0d: got %h want %h", i, cyc, o_q[i], eq);
            end
            n_cmp++;
            if (o_hex[i] !== eh || o_hv[i] !== ev) begin
                n_mis++; $display("FAIL hex/hv inst%0d cyc%0d: got %h/%b want %h/%b", i, cyc, o_hex[i], o_hv[i], eh, ev);
            end
            n_cmp++;
            if ({o_done[i], o_err[i], o_bad[i]} !== {m_done[i], m_err[i], m_bad[i]}) begin
                n_mis++; $display("FAIL pulses inst%0d cyc%0d: got done/err/bad %b%b%b want %b%b%b", i, cyc,
                                  o_done[i], o_err[i], o_bad[i], m_done[i], m_err[i], m_bad[i]);
            end
            n_cmp++;
            if (o_stale[i] !== (m_idle[i] == TMO[i])) begin
                n_mis++; $display("FAIL stale inst%0d cyc%0d: got %b want %b", i, cyc, o_stale[i], m_idle[i] == TMO[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        blank_all();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_q[i] !== 40'd0 || o_hex[i] !== 20'd0 || o_hv[i] !== 5'd0 ||
                o_done[i] !== 1'b0 || o_err[i] !== 1'b0 || o_bad[i] !== 1'b0 || o_stale[i] !== 1'b0) begin
                n_mis++; $display("FAIL reset_state inst%0d: got q=%h hex=%h hv=%b want all zero", i, o_q[i], o_hex[i], o_hv[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] pat [5];
        int first_done;
        int n_done;
        pat = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
        first_done = -1;
        n_done = 0;
        for (int j = 0; j < 16; j++) begin
            blank_all();
            if (j < 15) begin
                in_sel[0] = sel_of(j % 5);
                in_seg[0] = pat[j % 5];
            end
            step();
            if (o_done[0]) begin
                n_done++;
                if (first_done < 0) first_done = j;
            end
        end
        n_cmp++;
        if (n_done != 3 || first_done != 5) begin
            n_mis++; $display("FAIL scan_frame_done: got %0d pulses first at %0d want 3 first at 5", n_done, first_done);
        end
        n_cmp++;
        if (o_hex[0] !== 20'h54321) begin
            n_mis++; $display("FAIL scan_hex: got %h want 54321", o_hex[0]);
        end
        n_cmp++;
        if (o_hv[0] !== 5'h1F) begin
            n_mis++; $display("FAIL scan_hv: got %b want 11111", o_hv[0]);
        end
    endtask

    task automatic test_order();
        int seq [10];
        int n_done;
        bit err3;
        bit err2;
        bit done_last;
        seq = '{0, 1, 3, 2, 4, 0, 1, 2, 3, 4};
        n_done = 0; err3 = 1'b0; err2 = 1'b0; done_last = 1'b0;
        for (int j = 0; j < 11; j++) begin
            blank_all();
            if (j < 10) begin
                in_sel[0] = sel_of(seq[j]);
                in_seg[0] = pat_of(seq[j]);
            end
            step();
            if (j == 3) err3 = o_err[0];
            if (j == 4) err2 = o_err[0];
            if (o_done[0]) n_done++;
            if (j == 10) done_last = o_done[0];
        end
        n_cmp++;
        if (!err3 || !err2) begin
            n_mis++; $display("FAIL order_seq_err: got slot3/slot2 err %b/%b want 1/1", err3, err2);
        end
        n_cmp++;
        if (n_done != 1 || !done_last) begin
            n_mis++; $display("FAIL order_frame_done: got %0d pulses last=%b want 1 on clean run", n_done, done_last);
        end
    endtask

    task automatic test_bad_sel();
        logic [4:0]  sq [10];
        logic [39:0] q_before;
        bit          saw_bad;
        bit          q_same;
        int          n_done;
        int          n_pulse_tail;
        sq = '{5'b11110, 5'b11101, 5'b10101, 5'b11011, 5'b10111, 5'b01111,
               5'b11111, 5'b11111, 5'b11111, 5'b11111};
        saw_bad = 1'b0; q_same = 1'b0; n_done = 0; n_pulse_tail = 0; q_before = '0;
        for (int j = 0; j < 10; j++) begin
            blank_all();
            in_sel[0] = sq[j];
            in_seg[0] = 8'h7F;
            step();
            if (j == 2) q_before = o_q[0];
            if (j == 3) begin
                saw_bad = o_bad[0];
                q_same  = (o_q[0] === q_before);
            end
            if (o_done[0]) n_done++;
            if (j >= 6 && (o_done[0] || o_err[0] || o_bad[0])) n_pulse_tail++;
        end
        n_cmp++;
        if (!saw_bad || !q_same) begin
            n_mis++; $display("FAIL bad_sel_pulse: got bad=%b q_unchanged=%b want 1/1", saw_bad, q_same);
        end
        n_cmp++;
        if (n_done != 0) begin
            n_mis++; $display("FAIL bad_sel_no_frame: got %0d frame_done want 0", n_done);
        end
        n_cmp++;
        if (n_pulse_tail != 0) begin
            n_mis++; $display("FAIL blank_no_pulse: got %0d pulses want 0", n_pulse_tail);
        end
    endtask

    task automatic test_decode();
        logic [7:0] vals [3];
        logic [3:0] want_h [3];
        logic       want_v [3];
        vals   = '{8'h80, 8'h49, 8'hBF};
        want_h = '{4'hF, 4'hF, 4'h0};
        want_v = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            for (int j = 0; j < 5; j++) begin
                blank_all();
                in_sel[0] = sel_of(j);
                in_seg[0] = (j == 2) ? vals[t] : pat_of(j);
                step();
                if (j == 3) begin
                    n_cmp++;
                    if (o_q[0][23:16] !== vals[t] || o_hex[0][11:8] !== want_h[t] || o_hv[0][2] !== want_v[t]) begin
                        n_mis++; $display("FAIL decode_%h: got q=%h hex=%h hv=%b want q=%h hex=%h hv=%b", vals[t],
                                          o_q[0][23:16], o_hex[0][11:8], o_hv[0][2], vals[t], want_h[t], want_v[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_dwell();
        int  n_pulse;
        int  n_done;
        bit  ok;
        logic [7:0] pat;
        n_pulse = 0;
        for (int j = 0; j < 20; j++) begin
            blank_all();
            in_sel[1] = sel_of((j / 2) % 5);
            in_seg[1] = pat_of((j / 2) % 5);
            step();
            if (o_done[1] || o_err[1] || o_bad[1]) n_pulse++;
        end
        n_cmp++;
        if (o_q[1] !== 40'd0 || o_hv[1] !== 5'd0 || n_pulse != 0) begin
            n_mis++; $display("FAIL dwell_short: got q=%h hv=%b pulses=%0d want 0/0/0", o_q[1], o_hv[1], n_pulse);
        end
        n_pulse = 0;
        n_done  = 0;
        for (int k = 0; k < 5; k++) begin
            ok  = 1'b1;
            pat = {1'b1, DIG[k + 5]};
            for (int d = 0; d < 5; d++) begin
                blank_all();
                in_sel[1] = sel_of(k);
                in_seg[1] = pat;
                step();
                if (o_q[1][8*k +: 8] !== ((d >= 3) ? pat : 8'h00)) ok = 1'b0;
                if (o_done[1]) n_done++;
                if (o_err[1] || o_bad[1]) n_pulse++;
            end
            n_cmp++;
            if (!ok) begin
                n_mis++; $display("FAIL dwell_capture slot%0d: got q=%h want %h from dwell cycle 3", k, o_q[1][8*k +: 8], pat);
            end
        end
        n_cmp++;
        if (n_done != 1 || n_pulse != 0) begin
            n_mis++; $display("FAIL dwell_pulses: got done=%0d other=%0d want 1/0", n_done, n_pulse);
        end
    endtask

    task automatic test_stale();
        logic st [14];
        for (int j = 0; j < 14; j++) begin
            blank_all();
            if (j == 0)  begin in_sel[2] = sel_of(0); in_seg[2] = pat_of(7); end
            if (j == 12) begin in_sel[2] = sel_of(1); in_seg[2] = pat_of(8); end
            step();
            st[j] = o_stale[2];
        end
        n_cmp++;
        if (st[0] !== 1'b1 || st[1] !== 1'b0) begin
            n_mis++; $display("FAIL stale_clear_on_capture: got %b,%b want 1,0", st[0], st[1]);
        end
        n_cmp++;
        if (st[8] !== 1'b0 || st[9] !== 1'b1) begin
            n_mis++; $display("FAIL stale_rise: got cyc7=%b cyc8=%b after capture want 0,1", st[8], st[9]);
        end
        n_cmp++;
        if (st[12] !== 1'b1 || st[13] !== 1'b0) begin
            n_mis++; $display("FAIL stale_reclear: got %b,%b want 1,0", st[12], st[13]);
        end
    endtask

    task automatic test_reset_mid();
        bit done_ok;
        int n_err;
        n_err = 0; done_ok = 1'b0;
        for (int j = 0; j < 10; j++) begin
            blank_all();
            if (j < 4)      begin in_sel[0] = sel_of(j);     in_seg[0] = pat_of(j); end
            else if (j < 9) begin in_sel[0] = sel_of(j - 4); in_seg[0] = pat_of(j); end
            rst = (j == 3);
            step();
            if (j == 3) begin
                n_cmp++;
                if (o_q[0] !== 40'd0 || o_hex[0] !== 20'd0 || o_hv[0] !== 5'd0 ||
                    o_done[0] || o_err[0] || o_bad[0] || o_stale[0]) begin
                    n_mis++; $display("FAIL mid_reset: got q=%h hex=%h hv=%b want all zero", o_q[0], o_hex[0], o_hv[0]);
                end
            end
            if (j > 3 && (o_err[0] || o_bad[0])) n_err++;
            if (j == 9) done_ok = o_done[0];
        end
        rst = 1'b0;
        n_cmp++;
        if (!done_ok || n_err != 0) begin
            n_mis++; $display("FAIL post_reset_frame: got done=%b errs=%0d want 1/0", done_ok, n_err);
        end
    endtask

    task automatic rand_sel(inout int nxt, output logic [4:0] sel);
        int r;
        int k;
        logic [4:0] v;
        r = $urandom_range(0, 99);
        if (r < 70) begin
            sel = sel_of(nxt); nxt = (nxt + 1) % 5;
        end else if (r < 85) begin
            k = $urandom_range(0, 4); sel = sel_of(k); nxt = (k + 1) % 5;
        end else if (r < 93) begin
            sel = 5'b10101;
            for (int t = 0; t < 50; t++) begin
                v = 5'($urandom_range(0, 31));
                if ($countones(~v) >= 2) begin sel = v; break; end
            end
        end else begin
            sel = 5'h1F;
        end
    endtask

    function automatic logic [7:0] rand_seg();
        if ($urandom_range(0, 3) != 0) rand_seg = {1'($urandom_range(0, 1)), DIG[$urandom_range(0, 9)]};
        else rand_seg = 8'($urandom_range(0, 255));
    endfunction

    task automatic test_random();
        int nxt [3];
        int hold;
        int quiet;
        logic [4:0] hsel;
        logic [7:0] hseg;
        logic [4:0] s;
        nxt = '{0, 0, 0};
        hold = 0; quiet = 0; hsel = 5'h1F; hseg = 8'h00;
        for (int j = 0; j < 400; j++) begin
            rand_sel(nxt[0], s);
            in_sel[0] = s; in_seg[0] = rand_seg();
            if (hold == 0) begin
                hold = $urandom_range(1, 6);
                rand_sel(nxt[1], hsel);
                hseg = rand_seg();
            end
            hold--;
            in_sel[1] = hsel; in_seg[1] = hseg;
            if (quiet > 0) begin
                quiet--;
                in_sel[2] = 5'h1F; in_seg[2] = rand_seg();
            end else begin
                rand_sel(nxt[2], s);
                in_sel[2] = s; in_seg[2] = rand_seg();
                if ($urandom_range(0, 19) == 0) quiet = $urandom_range(5, 14);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        blank_all();
        for (int i = 0; i < 3; i++) model_reset(i);
        test_reset();
        test_scan();
        test_order();
        test_bad_sel();
        test_decode();
        test_dwell();
        test_stale();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/scan_capture.md
# scan_capture

Receiving end of the five-digit multiplexed seven-segment scan bus in the dice game. It samples the shared segment bus and active-low digit selects, checks the scan order, and rebuilds the five digit patterns into per-slot registers. It also decodes each pattern back to a BCD digit and reports frame completion, order errors, illegal selects and a stalled scan. It is used for display self-check and for bench scoreboarding of the display path.

## Interface

Parameters:
- STABLE_CYC, 1: cycles a select must stay unchanged before its slot is captured (legal range 1..15).
- TIMEOUT, 255: cycles without a capture before `stale` is raised (legal range 1..65535).

Ports:
- clk  in  1  single clock. All state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  8  segment bus. Bit 7 = dp, bits 6:0 = g..a, active-high.
- sel_in  in  5  digit selects, active-low. Slot k is selected when only bit k is 0.
- q  out  40  captured patterns. Slot k is at [8k+7:8k].
- hex  out  20  decoded digits. Slot k is at [4k+3:4k].
- hv  out  5  bit k = 1 when hex slot k holds a valid decode.
- frame_done  out  1  one-cycle pulse when slots 0..4 have been captured in order.
- seq_err  out  1  one-cycle pulse when a capture is out of order.
- bad_sel  out  1  one-cycle pulse for an illegal select.
- stale  out  1  level. Held high while no capture has occurred for TIMEOUT cycles.

## Operation

- Input stage: seg_in and sel_in are registered into r_seg and r_sel every cycle.
- Dwell counter cnt (4 bits):
  - Set to 1 when r_sel differs from its previous value.
  - Otherwise increments, saturating at 15.
  - A dwell is "qualified" on the single cycle where cnt == STABLE_CYC. So there is at most one action per dwell, however long the select is held.
- Qualified dwell with r_sel one-hot-low (slot k):
  - Capture: r_seg is written to q slot k.
  - Decode: hex slot k and hv[k] are updated from the capture.
  - Order check:
    - If k == exp: prog advances.
    - If k == 4 and prog already had slots 0..3: pulse frame_done and clear prog.
    - If k != exp: pulse seq_err and restart prog with slot k only.
  - exp is then set to (k+1) mod 5 in every case.
  - The idle counter is cleared.
- Qualified dwell with r_sel == 5'b11111 (blanking): ignored. No pulse, no state change.
- Qualified dwell with any other r_sel value:
  - Pulse bad_sel and clear prog.
  - exp is unchanged and nothing is captured.
- Decode uses seg bits 6:0 only; dp is ignored.
  - Valid patterns: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9. These give hv[k]=1 and the matching hex.
  - Any other pattern gives hex=4'hF and hv[k]=0.
- Idle counter:
  - Increments on every cycle without a capture, saturating at TIMEOUT.
  - stale = 1 while the counter equals TIMEOUT.
  - stale clears on the edge that performs the next capture.
- Reset values: q=0, hex=0, hv=0, frame_done=0, seq_err=0, bad_sel=0, stale=0.
- Reset state: exp=0, prog empty, idle counter 0, cnt=0.
- r_sel resets to 5'b11111, so the first real select is seen as a change.
- rst asserted mid-frame discards the partial frame. No pulse is emitted for the aborted frame.

## Timing

- Latency, from sel_in/seg_in valid before edge E0:
  - r_* are loaded at E0.
  - With STABLE_CYC=1, q, hex, hv and any pulse update at E1.
  - In general the update is at edge E(STABLE_CYC).
- The designed scanner holds each select for exactly 1 cycle. With STABLE_CYC=1, every scan cycle is captured back-to-back with no gap.
- Pulses are registered, last exactly one cycle, and are never asserted together. Only one qualified dwell can occur per cycle.
- frame_done for a frame coincides with the slot-4 q update.
- stale rises exactly TIMEOUT cycles after the last capture edge.

## Test plan

- Reset, then continuous scan with STABLE_CYC=1. Slots 0..4 carry 06,5B,4F,66,6D.
  - Required: hex = {5,4,3,2,1} (slot4..slot0) and hv=5'h1F.
  - Required: frame_done pulses every 5th cycle, starting 5 cycles after the first select.
- Scan order 0,1,3,2,4.
  - Required: seq_err on the slot-3 capture and again on the slot-2 capture.
  - Required: no frame_done until the next clean 0..4 run.
- sel_in=5'b10101 for one cycle mid-frame.
  - Required: bad_sel pulse, no q change, and no frame_done at the following slot 4.
  - Required: 5'b11111 for 3 cycles produces no pulse.
- Slot 2 carries 8'h80 or 8'h49.
  - Required: q slot 2 = that value, hex slot 2 = F, hv[2]=0.
  - Required: 8'hBF decodes to 0 with hv[2]=1.
- STABLE_CYC=3, each select held 2 cycles.
  - Required: no capture and no pulses.
  - With selects held 5 cycles: exactly one capture per dwell, on the 3rd cycle of the dwell.
- TIMEOUT=8 and the scan is stopped.
  - Required: stale rises 8 cycles after the last capture and clears on the next capture.
  - Required: asserting rst mid-frame clears all outputs on the next edge.
